// File: rtl/elevator_pkg.sv
// Shared elevator types and constants.
package elevator_pkg;
    localparam int FLOOR_W       = 3;
    localparam int DEF_TOP_FLOOR = 7;

    typedef enum logic [2:0] {
        CLOSED,
        MOVE_UP,
        MOVE_DN,
        OPENING,
        OPENED,
        CLOSING
    } state_t;
endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter with zero flag; shared by travel and door strokes.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);
    // load wins over decrement; the count saturates at zero
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/car_drive.sv
// Elevator car drive: travel between floors and door strokes, with interlocks.
module car_drive
    import elevator_pkg::*;
#(
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 4,
    parameter int TOP_FLOOR   = DEF_TOP_FLOOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               open,
    input  logic               close,
    output logic [FLOOR_W-1:0] pfloor,
    output logic               arrive,
    output logic               moving,
    output logic               door_open,
    output logic               door_closed,
    output logic               fault
);
    localparam int CNT_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    // Timer is loaded with N-1 on entry so the state lasts exactly N cycles
    localparam logic [CW-1:0]      FLOOR_LD = CW'(FLOOR_TICKS - 1);
    localparam logic [CW-1:0]      DOOR_LD  = CW'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP      = FLOOR_W'(TOP_FLOOR);

    state_t              state, state_n;
    logic                ld, dec, zero, flt, arr;
    logic [CW-1:0]       ld_val, cnt;
    logic [FLOOR_W-1:0]  floor_n;

    tick_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .dec      (dec),
        .load_val (ld_val),
        .count    (cnt),
        .zero     (zero)
    );

    // Next state, timer control and next output values
    always_comb begin
        state_n = state;
        ld      = 1'b0;
        dec     = 1'b0;
        ld_val  = DOOR_LD;
        flt     = 1'b0;
        arr     = 1'b0;
        floor_n = pfloor;
        case (state)
            CLOSED: begin
                if (open) begin
                    state_n = OPENING;
                    ld      = 1'b1;
                end else if (up && down) begin
                    flt = 1'b1;
                end else if (up) begin
                    if (pfloor >= TOP) flt = 1'b1;
                    else begin
                        state_n = MOVE_UP;
                        ld      = 1'b1;
                        ld_val  = FLOOR_LD;
                    end
                end else if (down) begin
                    if (pfloor == '0) flt = 1'b1;
                    else begin
                        state_n = MOVE_DN;
                        ld      = 1'b1;
                        ld_val  = FLOOR_LD;
                    end
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (zero) begin
                    state_n = CLOSED;
                    arr     = 1'b1;
                    floor_n = (state == MOVE_UP) ? pfloor + 1'b1 : pfloor - 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            OPENING: begin
                if (zero) state_n = OPENED;
                else      dec     = 1'b1;
            end
            OPENED: begin
                // door interlock: motion requests with open doors are rejected
                if (up || down) flt = 1'b1;
                if (close && !open) begin
                    state_n = CLOSING;
                    ld      = 1'b1;
                end
            end
            CLOSING: begin
                // an open request reverses the stroke with a full reload
                if (open) begin
                    state_n = OPENING;
                    ld      = 1'b1;
                end else if (zero) begin
                    state_n = CLOSED;
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_n = CLOSED;
        endcase
    end

    // State and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLOSED;
            pfloor      <= '0;
            arrive      <= 1'b0;
            fault       <= 1'b0;
            moving      <= 1'b0;
            door_open   <= 1'b0;
            door_closed <= 1'b1;
        end else begin
            state       <= state_n;
            pfloor      <= floor_n;
            arrive      <= arr;
            fault       <= flt;
            moving      <= (state_n == MOVE_UP) || (state_n == MOVE_DN);
            door_open   <= (state_n == OPENED);
            door_closed <= (state_n == CLOSED) || (state_n == MOVE_UP) || (state_n == MOVE_DN);
        end
    end
endmodule

// File: tb/tb_car_drive.sv
// Self-checking bench for car_drive: directed scenarios plus random commands
// against a cycle-count model of the car.
module tb_car_drive;
    localparam int F   = 8;
    localparam int D   = 4;
    localparam int TOP = 7;

    logic       clk, rst, up, down, open, close;
    logic [2:0] pfloor;
    logic       arrive, moving, door_open, door_closed, fault;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    car_drive #(.FLOOR_TICKS(F), .DOOR_TICKS(D), .TOP_FLOOR(TOP)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .open(open), .close(close),
        .pfloor(pfloor), .arrive(arrive), .moving(moving),
        .door_open(door_open), .door_closed(door_closed), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: remaining travel cycles, remaining door stroke cycles, door target
    int m_floor = 0, m_travel = 0, m_dir = 0, m_stroke = 0;
    bit m_opening = 0, m_open = 0, m_arrive = 0, m_fault = 0;

    always @(posedge clk) begin
        m_arrive = 0;
        m_fault  = 0;
        if (rst) begin
            m_floor = 0; m_travel = 0; m_stroke = 0; m_open = 0; m_opening = 0;
        end else if (m_travel > 0) begin
            m_travel--;
            if (m_travel == 0) begin
                m_floor += m_dir;
                m_arrive = 1;
            end
        end else if (m_stroke > 0) begin
            if (!m_opening && open) begin
                m_opening = 1;
                m_stroke  = D;
            end else begin
                m_stroke--;
                if (m_stroke == 0) m_open = m_opening;
            end
        end else if (m_open) begin
            if (up || down) m_fault = 1;
            if (close && !open) begin
                m_open = 0; m_opening = 0; m_stroke = D;
            end
        end else begin
            if (open) begin
                m_opening = 1; m_stroke = D;
            end else if (up && down) m_fault = 1;
            else if (up) begin
                if (m_floor == TOP) m_fault = 1;
                else begin m_travel = F; m_dir = 1; end
            end else if (down) begin
                if (m_floor == 0) m_fault = 1;
                else begin m_travel = F; m_dir = -1; end
            end
        end
    end

    // Every cycle after reset: DUT outputs against the model
    always @(negedge clk) begin
        if (started) begin
            chk("pfloor", int'(pfloor), m_floor);
            chk("arrive", int'(arrive), int'(m_arrive));
            chk("fault", int'(fault), int'(m_fault));
            chk("moving", int'(moving), int'(m_travel > 0));
            chk("door_open", int'(door_open), int'(m_open && m_stroke == 0));
            chk("door_closed", int'(door_closed), int'(!m_open && m_stroke == 0));
            if (moving && !door_closed) chk("interlock", 1, 0);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic one_up();
        up = 1; step(); up = 0;
        repeat (F) step();
    endtask

    int mv, arr;

    initial begin
        rst = 1; up = 0; down = 0; open = 0; close = 0;
        step();
        started = 1;
        chk("rst_pfloor", int'(pfloor), 0);
        chk("rst_door_closed", int'(door_closed), 1);
        chk("rst_moving", int'(moving), 0);
        rst = 0;

        // single move from floor 0
        up = 1; step(); up = 0;
        mv = 0; arr = 0;
        if (moving) mv++;
        for (int i = 0; i < 20; i++) begin
            step();
            if (moving) mv++;
            if (arrive) arr++;
        end
        chk("move_cycles", mv, 8);
        chk("move_arrive_cnt", arr, 1);
        chk("move_pfloor", int'(pfloor), 1);

        // climb to the top, then one more up
        do_reset();
        repeat (7) one_up();
        chk("top_pfloor", int'(pfloor), 7);
        chk("model_floor", m_floor, 7);
        up = 1; step(); up = 0;
        chk("top_fault", int'(fault), 1);
        chk("top_moving", int'(moving), 0);
        chk("top_stay", int'(pfloor), 7);
        step();
        chk("top_fault_pulse", int'(fault), 0);

        // door open, then interlock
        open = 1; step(); open = 0;
        chk("opening_closed", int'(door_closed), 0);
        repeat (3) step();
        chk("opening_not_yet", int'(door_open), 0);
        step();
        chk("opened", int'(door_open), 1);
        up = 1; step(); up = 0;
        chk("interlock_fault", int'(fault), 1);
        chk("interlock_moving", int'(moving), 0);

        // close, reverse two cycles into the stroke
        close = 1; step(); close = 0;
        step();
        open = 1; step(); open = 0;
        chk("reopen_open", int'(door_open), 0);
        repeat (3) step();
        chk("reopen_not_yet", int'(door_open), 0);
        step();
        chk("reopened", int'(door_open), 1);
        close = 1; step(); close = 0;
        repeat (D) step();
        chk("closed_again", int'(door_closed), 1);

        // up+down at floor 3, then reset mid-move
        do_reset();
        repeat (3) one_up();
        up = 1; down = 1; step(); up = 0; down = 0;
        chk("both_fault", int'(fault), 1);
        chk("both_pfloor", int'(pfloor), 3);
        up = 1; step(); up = 0;
        repeat (3) step();
        chk("midmove_moving", int'(moving), 1);
        rst = 1; step(); rst = 0;
        chk("midrst_pfloor", int'(pfloor), 0);
        chk("midrst_moving", int'(moving), 0);
        chk("midrst_arrive", int'(arrive), 0);

        // random commands, occasional reset
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            up    = ($urandom_range(0, 2) == 0);
            down  = ($urandom_range(0, 3) == 0);
            open  = ($urandom_range(0, 5) == 0);
            close = ($urandom_range(0, 2) == 0);
            step();
        end
        rst = 0; up = 0; down = 0; open = 0; close = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/car_drive.md
CAR_DRIVE -- requirements
Module: car_drive

Interface
REQ-001 SHALL have parameter FLOOR_TICKS, default 8: clock cycles to travel one floor (>=2).
REQ-002 SHALL have parameter DOOR_TICKS, default 4: clock cycles for a full door open or close stroke (>=2).
REQ-003 SHALL have parameter TOP_FLOOR, default 7: highest floor index (ground = 0).
REQ-004 Ports SHALL be, in this order:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- up  input  1  controller command: move one floor up.
- down  input  1  controller command: move one floor down.
- open  input  1  controller command: open doors.
- close  input  1  controller command: close doors.
- pfloor  output  3  present floor of car.
- arrive  output  1  one-cycle pulse: car reached a new floor.
- moving  output  1  car in motion.
- door_open  output  1  doors fully open.
- door_closed  output  1  doors fully closed.
- fault  output  1  one-cycle pulse: illegal command rejected.

Function
REQ-005 SHALL implement states CLOSED, MOVE_UP, MOVE_DN, OPENING, OPENED, CLOSING, with a single down-counter for travel and door timing.
REQ-006 CLOSED: on the same edge, open=1 SHALL enter OPENING; open has priority over up/down and raises no fault.
REQ-007 CLOSED: up=1 and down=1 together (open=0) SHALL pulse fault and remain in CLOSED.
REQ-008 CLOSED: up=1 with pfloor<TOP_FLOOR SHALL enter MOVE_UP; at TOP_FLOOR it SHALL pulse fault and stay.
REQ-009 CLOSED: down=1 with pfloor>0 SHALL enter MOVE_DN; at floor 0 it SHALL pulse fault and stay.
REQ-010 CLOSED: close alone SHALL be ignored with no fault.
REQ-011 MOVE_UP/MOVE_DN: moving=1 for exactly FLOOR_TICKS cycles; all commands ignored, no fault.
REQ-012 Motion end: on the edge leaving MOVE_*, pfloor SHALL increment/decrement by 1, arrive SHALL pulse for one cycle and state SHALL return to CLOSED.
REQ-013 OPENING: door_open=0, door_closed=0 for DOOR_TICKS cycles, then OPENED; commands ignored.
REQ-014 OPENED: door_open=1; close=1 with open=0 SHALL enter CLOSING; open and close together SHALL stay OPENED.
REQ-015 OPENED: up or down SHALL pulse fault and be ignored (door interlock).
REQ-016 CLOSING: door_open=0, door_closed=0 for DOOR_TICKS cycles, then CLOSED with door_closed=1.
REQ-017 CLOSING: open=1 at any cycle SHALL reverse to OPENING with counter reloaded to full DOOR_TICKS.
REQ-018 moving and door_closed=0 SHALL never be true simultaneously; pfloor SHALL never exceed TOP_FLOOR.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 rst=1 SHALL, on the next edge, force CLOSED, pfloor=0, counter=0, door_closed=1, door_open=0, moving=0, arrive=0, fault=0.
REQ-021 rst SHALL take precedence over every command and apply mid-motion or mid-stroke with no arrive pulse.

Structure
REQ-022 Shared package elevator_pkg SHALL hold the state enum, FLOOR_W=3 and TOP_FLOOR default.
REQ-023 The load/decrement/zero-flag timer SHALL be sub-module tick_timer, reused for travel and door strokes.

Verification
REQ-024 Reset, then up held 1 cycle at floor 0 -> moving=1 for 8 cycles, then pfloor=1 and arrive pulses once.
REQ-025 Seven single up commands from floor 0 -> pfloor=7; one more up -> fault pulse, pfloor stays 7, moving stays 0.
REQ-026 open in CLOSED -> door_closed falls next cycle, door_open=1 after 4 cycles; up while OPENED -> fault pulse, no motion.
REQ-027 close, then open 2 cycles into CLOSING -> returns to OPENING, door_open=1 exactly 4 cycles after reopen.
REQ-028 up and down together in CLOSED at floor 3 -> fault pulse, pfloor=3; rst at cycle 4 of a move -> pfloor=0, moving=0, no arrive.
